match_event_counter: RTL and testbench

- Downstream consumer of the 2-bit sequence-detector FSM; takes that detector's level output `ans` and turns it into match episodes.
- An episode is a maximal run of cycles with `ans`=1.
- Counts episodes, measures each episode's dwell length in cycles, and hands one report per finished episode to the next stage over a valid/ready handshake.
- Sits between the sequence detector and the status/readout logic.

---
 rtl/match_event_counter_pkg.sv | 11 +
 rtl/match_event_counter_sat_counter.sv | 35 +++
 rtl/match_event_counter.sv | 136 +++++++++++++
 tb/tb_match_event_counter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/match_event_counter_pkg.sv
// Shared constants for the match episode counter: FSM encodings and default widths.
package match_event_counter_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int LEN_W_DEF = 8;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_MATCH = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

endpackage

// File: rtl/match_event_counter_sat_counter.sv
// Saturating up-counter: synchronous clear, load of a start value, and increment
// that sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (load) begin
      value_d = load_val;
    end else if (inc && (value_q != '1)) begin
      value_d = value_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/match_event_counter.sv
// Turns the sequence detector's ans level into counted match episodes and
// emits one dwell-length report per finished episode over valid/ready.
//
//   state | meaning
//   IDLE  | waiting for ans=1 to start an episode
//   MATCH | inside a counted episode, dwell accumulating
//   DRAIN | episode aborted by clr, waiting for ans=0 without counting
module match_event_counter
  import match_event_counter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             ans,
  input  logic             rpt_ready,
  output logic             rpt_valid,
  output logic [LEN_W-1:0] rpt_len,
  output logic [CNT_W-1:0] rpt_idx,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             in_match,
  output logic             ovf
);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] evt_q, evt_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic             match_q, match_d;
  logic [LEN_W-1:0] dwell;
  logic             dwell_load, dwell_inc;
  logic             ep_end;
  logic             accept;

  assign accept = valid_q && rpt_ready;

  sat_counter #(.W(LEN_W)) u_dwell (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (dwell_load),
    .load_val (LEN_W'(1)),
    .inc      (dwell_inc),
    .value    (dwell)
  );

  always_comb begin
    state_d    = state_q;
    evt_d      = evt_q;
    idx_d      = idx_q;
    len_d      = len_q;
    valid_d    = valid_q;
    ovf_d      = ovf_q;
    dwell_load = 1'b0;
    dwell_inc  = 1'b0;
    ep_end     = 1'b0;

    if (clr) begin
      state_d = ans ? ST_DRAIN : ST_IDLE;
      evt_d   = '0;
      idx_d   = '0;
      len_d   = '0;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ans) begin
            state_d    = ST_MATCH;
            evt_d      = evt_q + CNT_W'(1);
            dwell_load = 1'b1;
          end
        end
        ST_MATCH: begin
          if (ans) begin
            dwell_inc = 1'b1;
          end else begin
            state_d = ST_IDLE;
            ep_end  = 1'b1;
          end
        end
        ST_DRAIN: begin
          if (!ans) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase

      if (accept) valid_d = 1'b0;

      // An acceptance on this same edge frees the slot for the new report.
      if (ep_end) begin
        if (!valid_q || rpt_ready) begin
          valid_d = 1'b1;
          len_d   = dwell;
          idx_d   = evt_q;
        end else begin
          ovf_d = 1'b1;
        end
      end
    end

    match_d = (state_d == ST_MATCH);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      evt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      evt_q   <= evt_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      match_q <= match_d;
    end
  end

  assign rpt_valid = valid_q;
  assign rpt_len   = len_q;
  assign rpt_idx   = idx_q;
  assign evt_cnt   = evt_q;
  assign in_match  = match_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_match_event_counter.sv
// Bench for match_event_counter: vector table, directed corner sequences and a
// randomized run against an episode-level reference model.
module tb_match_event_counter;

  localparam int CNT_W = 8;
  localparam int LEN_W = 8;
  localparam int LMAX  = (1 << LEN_W) - 1;
  localparam int CMOD  = (1 << CNT_W);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clr;
  logic             ans;
  logic             rpt_ready;
  logic             rpt_valid;
  logic [LEN_W-1:0] rpt_len;
  logic [CNT_W-1:0] rpt_idx;
  logic [CNT_W-1:0] evt_cnt;
  logic             in_match;
  logic             ovf;

  match_event_counter #(.CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .ans       (ans),
    .rpt_ready (rpt_ready),
    .rpt_valid (rpt_valid),
    .rpt_len   (rpt_len),
    .rpt_idx   (rpt_idx),
    .evt_cnt   (evt_cnt),
    .in_match  (in_match),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Episode-level reference: an episode is a run of ans=1 seen while not draining.
  bit m_active, m_drain, m_full, m_ovf;
  int m_run, m_eps, m_len, m_idx;

  function automatic void model_reset();
    m_active = 0; m_drain = 0; m_full = 0; m_ovf = 0;
    m_run = 0; m_eps = 0; m_len = 0; m_idx = 0;
  endfunction

  function automatic void model_edge(input bit c, input bit a, input bit r);
    if (c) begin
      model_reset();
      m_drain = a;
      return;
    end
    if (m_full && r) m_full = 0;
    if (m_drain) begin
      if (!a) m_drain = 0;
    end else if (m_active) begin
      if (a) m_run++;
      else begin
        m_active = 0;
        if (!m_full) begin
          m_full = 1;
          m_len  = (m_run > LMAX) ? LMAX : m_run;
          m_idx  = m_eps % CMOD;
        end else m_ovf = 1;
      end
    end else if (a) begin
      m_active = 1;
      m_eps++;
      m_run = 1;
    end
  endfunction

  task automatic step(input bit c, input bit a, input bit r);
    clr = c; ans = a; rpt_ready = r;
    @(posedge clk);
    model_edge(c, a, r);
    @(negedge clk);
  endtask

  task automatic check_model(input string nm);
    chk({nm, "_valid"}, int'(rpt_valid), int'(m_full));
    chk({nm, "_len"},   int'(rpt_len),   m_len);
    chk({nm, "_idx"},   int'(rpt_idx),   m_idx);
    chk({nm, "_evt"},   int'(evt_cnt),   m_eps % CMOD);
    chk({nm, "_match"}, int'(in_match),  int'(m_active));
    chk({nm, "_ovf"},   int'(ovf),       int'(m_ovf));
  endtask

  typedef struct {
    bit c, a, r;
    bit v;
    int len, idx, evt;
    bit m, o;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit c, bit a, bit r, bit v, int len, int idx, int evt, bit m, bit o);
    vec_t t;
    t.c = c; t.a = a; t.r = r; t.v = v; t.len = len; t.idx = idx; t.evt = evt; t.m = m; t.o = o;
    return t;
  endfunction

  initial begin
    bit ra;
    rst_n = 1'b0; clr = 1'b0; ans = 1'b0; rpt_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // async reset taken mid-cycle while in MATCH
    step(0, 1, 1);
    step(0, 1, 1);
    chk("pre_rst_match", int'(in_match), 1);
    chk("pre_rst_evt", int'(evt_cnt), 1);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_evt", int'(evt_cnt), 0);
    chk("arst_valid", int'(rpt_valid), 0);
    chk("arst_len", int'(rpt_len), 0);
    chk("arst_idx", int'(rpt_idx), 0);
    chk("arst_ovf", int'(ovf), 0);
    chk("arst_match", int'(in_match), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 1);
    chk("post_rst_evt", int'(evt_cnt), 1);
    chk("post_rst_match", int'(in_match), 1);

    // single report, drop on full slot, accept-and-load on same edge
    tbl.push_back(mk(1,0,1, 0,0,0,0,0,0));
    repeat (3) tbl.push_back(mk(0,1,1, 0,0,0,1,1,0));
    tbl.push_back(mk(0,0,1, 1,3,1,1,0,0));
    tbl.push_back(mk(0,0,1, 0,3,1,1,0,0));
    tbl.push_back(mk(1,0,0, 0,0,0,0,0,0));
    repeat (2) tbl.push_back(mk(0,1,0, 0,0,0,1,1,0));
    tbl.push_back(mk(0,0,0, 1,2,1,1,0,0));
    repeat (5) tbl.push_back(mk(0,1,0, 1,2,1,2,1,0));
    tbl.push_back(mk(0,0,0, 1,2,1,2,0,1));
    tbl.push_back(mk(0,0,0, 1,2,1,2,0,1));
    tbl.push_back(mk(1,0,0, 0,0,0,0,0,0));
    tbl.push_back(mk(0,1,0, 0,0,0,1,1,0));
    tbl.push_back(mk(0,0,0, 1,1,1,1,0,0));
    repeat (4) tbl.push_back(mk(0,1,0, 1,1,1,2,1,0));
    tbl.push_back(mk(0,0,1, 1,4,2,2,0,0));
    tbl.push_back(mk(0,0,1, 0,4,2,2,0,0));

    foreach (tbl[i]) begin
      step(tbl[i].c, tbl[i].a, tbl[i].r);
      chk($sformatf("tbl%0d_valid", i), int'(rpt_valid), int'(tbl[i].v));
      chk($sformatf("tbl%0d_len", i),   int'(rpt_len),   tbl[i].len);
      chk($sformatf("tbl%0d_idx", i),   int'(rpt_idx),   tbl[i].idx);
      chk($sformatf("tbl%0d_evt", i),   int'(evt_cnt),   tbl[i].evt);
      chk($sformatf("tbl%0d_match", i), int'(in_match),  int'(tbl[i].m));
      chk($sformatf("tbl%0d_ovf", i),   int'(ovf),       int'(tbl[i].o));
    end

    // dwell saturation, then clr mid-episode drains without a report
    step(1, 0, 1);
    repeat (300) step(0, 1, 1);
    chk("sat_match", int'(in_match), 1);
    step(0, 0, 0);
    chk("sat_valid", int'(rpt_valid), 1);
    chk("sat_len", int'(rpt_len), LMAX);
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 1, 0);
    chk("clr_evt", int'(evt_cnt), 0);
    chk("clr_match", int'(in_match), 0);
    chk("clr_valid", int'(rpt_valid), 0);
    chk("clr_ovf", int'(ovf), 0);
    step(0, 1, 0);
    step(0, 0, 0);
    chk("drain_valid", int'(rpt_valid), 0);
    chk("drain_evt", int'(evt_cnt), 0);
    step(0, 1, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    chk("after_drain_valid", int'(rpt_valid), 1);
    chk("after_drain_idx", int'(rpt_idx), 1);
    chk("after_drain_len", int'(rpt_len), 2);
    check_model("after_drain");

    // episode counter wrap
    step(1, 0, 1);
    repeat (CMOD) begin
      step(0, 1, 1);
      step(0, 0, 1);
    end
    chk("wrap_evt", int'(evt_cnt), 0);
    chk("wrap_valid", int'(rpt_valid), 1);
    chk("wrap_idx", int'(rpt_idx), 0);
    chk("wrap_len", int'(rpt_len), 1);
    chk("wrap_ovf", int'(ovf), 0);

    // randomized run against the episode model
    step(1, 0, 0);
    ra = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(3) == 0) ra = ~ra;
      step(($urandom_range(99) == 0), ra, 1'($urandom_range(1)));
      check_model($sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
